// File: rtl/grant_xfer_ctrl.sv
// grant_xfer_ctrl: consumes the round-robin arbiter's one-hot grant, captures
// the granted port's data word, hands it to a shared sink over valid/ready and
// returns a single-cycle ack to the winning requester.
// Optional feature macro: TIMEOUT_EN (abort a stalled transfer after TIMEOUT
// cycles without out_ready and pulse to_err).
module grant_xfer_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 8,
  parameter int SW      = 2,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    grant,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_src,
  output logic [N-1:0]    ack,
  output logic            busy,
  output logic            err_multi,
  output logic            to_err,
  output logic [15:0]     xfer_cnt
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Registered outputs and their next values
  logic            out_valid_reg, out_valid_next;
  logic [DW-1:0]   out_data_reg, out_data_next;
  logic [SW-1:0]   out_src_reg, out_src_next;
  logic [N-1:0]    ack_reg, ack_next;
  logic            busy_reg, busy_next;
  logic            err_multi_reg, err_multi_next;
  logic            to_err_reg, to_err_next;
  logic [15:0]     xfer_cnt_reg, xfer_cnt_next;

  // Grant decode
  logic [CW-1:0]   grant_cnt;
  logic [SW-1:0]   grant_idx;
  logic            grant_ok;
  logic            grant_multi;
  logic [DW-1:0]   port_word [N];
  logic [N-1:0]    src_onehot;
  logic            to_hit;

  // Parameter sanity: the index width must fit the port count exactly.
  if (SW != $clog2(N) || TIMEOUT < 1) begin : g_param_check
    $error("grant_xfer_ctrl: SW must equal clog2(N) and TIMEOUT must be >= 1");
  end

  // Unpack the flattened data bus and build the one-hot ack pattern for the
  // currently held source index.
  for (genvar gi = 0; gi < N; gi++) begin : g_port
    assign port_word[gi]  = wdata[gi*DW +: DW];
    assign src_onehot[gi] = (out_src_reg == SW'(gi));
  end

  // Count set grant bits and remember the position of a set bit.
  always_comb begin
    grant_cnt = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_cnt = grant_cnt + CW'(1);
        grant_idx = SW'(i);
      end
    end
  end

  assign grant_multi = (grant_cnt > CW'(1));
  // A one-hot grant only counts if the requester is still asking for it.
  assign grant_ok    = (grant_cnt == CW'(1)) && req[grant_idx];

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_reg;

  // The stall counter is zero whenever not in XFER, so each transfer starts
  // fresh; it counts XFER cycles spent without out_ready.
  always_ff @(posedge clk) begin
    if (rst || state_reg != ST_XFER || state_next != ST_XFER) begin
      to_cnt_reg <= '0;
    end else if (!out_ready) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  // The TIMEOUT-th stalled cycle aborts; a handshake in that cycle wins.
  assign to_hit = !out_ready && (to_cnt_reg == TW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!grant_multi && grant_ok) begin
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (out_ready) begin
          state_next = ST_ACK;
        end else if (to_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output next-value logic; pulses default low every cycle.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_src_next   = out_src_reg;
    ack_next       = '0;
    err_multi_next = 1'b0;
    to_err_next    = 1'b0;
    xfer_cnt_next  = xfer_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_multi) begin
          err_multi_next = 1'b1;
        end else if (grant_ok) begin
          out_valid_next = 1'b1;
          out_data_next  = port_word[grant_idx];
          out_src_next   = grant_idx;
        end
      end
      ST_XFER: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          ack_next       = src_onehot;
          xfer_cnt_next  = xfer_cnt_reg + 16'd1;
        end else if (to_hit) begin
          out_valid_next = 1'b0;
          to_err_next    = 1'b1;
        end
      end
      default: ;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      ack_reg       <= '0;
      busy_reg      <= 1'b0;
      err_multi_reg <= 1'b0;
      to_err_reg    <= 1'b0;
      xfer_cnt_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_src_reg   <= out_src_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      err_multi_reg <= err_multi_next;
      to_err_reg    <= to_err_next;
      xfer_cnt_reg  <= xfer_cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign ack       = ack_reg;
  assign busy      = busy_reg;
  assign err_multi = err_multi_reg;
  assign to_err    = to_err_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_grant_xfer_ctrl.sv
// tb_grant_xfer_ctrl: vector table, hand-written multi-cycle sequences and a
// randomized run checked against a transaction-level reference model.
// Honours TIMEOUT_EN when the design is built with it.
module tb_grant_xfer_ctrl;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int SW      = 2;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    grant;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic [N-1:0]    ack;
  logic            busy;
  logic            err_multi;
  logic            to_err;
  logic [15:0]     xfer_cnt;

  int checks = 0;
  int errors = 0;

  grant_xfer_ctrl #(.N(N), .DW(DW), .SW(SW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .grant(grant), .req(req), .wdata(wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .ack(ack), .busy(busy), .err_multi(err_multi),
    .to_err(to_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  // A transfer is "presented" until the sink takes it (or it times out),
  // then "acknowledged" for one cycle; everything else is idle.
  bit          m_presenting = 0;
  bit          m_acking     = 0;
  int          m_stall      = 0;
  logic        e_valid = 0, e_busy = 0, e_err = 0, e_to = 0;
  logic [7:0]  e_data = 0;
  logic [1:0]  e_src = 0;
  logic [3:0]  e_ack = 0;
  logic [15:0] e_cnt = 0;

  task automatic model_step();
    int ones;
    int k;
    e_err = 0;
    e_to  = 0;
    e_ack = 0;
    if (rst) begin
      m_presenting = 0; m_acking = 0; m_stall = 0;
      e_valid = 0; e_data = 0; e_src = 0; e_cnt = 0;
    end else if (m_acking) begin
      m_acking = 0;
    end else if (m_presenting) begin
      if (out_ready) begin
        m_presenting = 0;
        m_acking     = 1;
        e_valid      = 0;
        e_ack        = 4'(1 << e_src);
        e_cnt        = e_cnt + 16'd1;
      end else begin
        m_stall++;
`ifdef TIMEOUT_EN
        if (m_stall == TIMEOUT) begin
          m_presenting = 0;
          e_valid      = 0;
          e_to         = 1;
        end
`endif
      end
    end else begin
      ones = $countones(grant);
      if (ones > 1) begin
        e_err = 1;
      end else if (ones == 1) begin
        k = $clog2(int'(grant));
        if (req[k]) begin
          e_data       = wdata[k*DW +: DW];
          e_src        = 2'(k);
          e_valid      = 1;
          m_presenting = 1;
          m_stall      = 0;
        end
      end
    end
    e_busy = m_presenting || m_acking;
  endtask

  // One clock: the model sees the same inputs the DUT samples; outputs are
  // then observed on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] g, input logic [3:0] q,
                       input logic [31:0] w, input logic rdy);
    rst = r; grant = g; req = q; wdata = w; out_ready = rdy;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  grant;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        rdy;
    logic        v;
    logic [7:0]  data;
    logic [1:0]  src;
    logic [3:0]  ack;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    drive(1, 4'b1011, 4'b1111, 32'hDEADBEEF, 1);

    // reset, single transfer, multi-hot grant, stale grant
    vecs[0] = '{1, 4'b1011, 4'b1111, 32'hDEADBEEF, 1, 0, 8'h00, 2'd0, 4'b0000, 0, 0, 16'd0};
    vecs[1] = '{1, 4'b0100, 4'b0110, 32'h12345678, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 0, 16'd0};
    vecs[2] = '{0, 4'b0100, 4'b0100, 32'h00A50000, 1, 1, 8'hA5, 2'd2, 4'b0000, 1, 0, 16'd0};
    vecs[3] = '{0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'hA5, 2'd2, 4'b0100, 1, 0, 16'd1};
    vecs[4] = '{0, 4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'hA5, 2'd2, 4'b0000, 0, 0, 16'd1};
    vecs[5] = '{0, 4'b0110, 4'b0110, 32'h99887766, 1, 0, 8'hA5, 2'd2, 4'b0000, 0, 1, 16'd1};
    vecs[6] = '{0, 4'b1000, 4'b0000, 32'h55000000, 1, 0, 8'hA5, 2'd2, 4'b0000, 0, 0, 16'd1};
    vecs[7] = '{0, 4'b0000, 4'b1111, 32'h00000000, 1, 0, 8'hA5, 2'd2, 4'b0000, 0, 0, 16'd1};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst, vecs[i].grant, vecs[i].req, vecs[i].wdata, vecs[i].rdy);
      cycle();
      $display("vec %0d: grant=%b req=%b valid=%0b data=%h src=%0d ack=%b busy=%0b err=%0b cnt=%0d",
               i, vecs[i].grant, vecs[i].req, out_valid, out_data, out_src, ack, busy, err_multi, xfer_cnt);
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d.out_data", i),  32'(out_data),  32'(vecs[i].data));
      chk($sformatf("vec%0d.out_src", i),   32'(out_src),   32'(vecs[i].src));
      chk($sformatf("vec%0d.ack", i),       32'(ack),       32'(vecs[i].ack));
      chk($sformatf("vec%0d.busy", i),      32'(busy),      32'(vecs[i].busy));
      chk($sformatf("vec%0d.err_multi", i), 32'(err_multi), 32'(vecs[i].err));
      chk($sformatf("vec%0d.to_err", i),    32'(to_err),    32'd0);
      chk($sformatf("vec%0d.xfer_cnt", i),  32'(xfer_cnt),  32'(vecs[i].cnt));
    end

    // ---------------- backpressure, grant ignored during XFER ----------------
    drive(0, 4'b0001, 4'b0001, 32'h0000003C, 0);
    cycle();
    chk("bp.capture_valid", 32'(out_valid), 32'd1);
    chk("bp.capture_data", 32'(out_data), 32'h3C);
    chk("bp.capture_src", 32'(out_src), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(0, 4'b0010, 4'b0010, 32'h0000AA00, 0);
      else        drive(0, 4'b0000, 4'b0001, 32'h0000AA00, 0);
      cycle();
      chk($sformatf("bp.stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp.stall%0d_data", i), 32'(out_data), 32'h3C);
      chk($sformatf("bp.stall%0d_src", i), 32'(out_src), 32'd0);
      chk($sformatf("bp.stall%0d_ack", i), 32'(ack), 32'd0);
    end
    drive(0, 4'b0000, 4'b0000, 32'h0, 1);
    cycle();
    $display("bp: handshake ack=%b cnt=%0d", ack, xfer_cnt);
    chk("bp.ack", 32'(ack), 32'b0001);
    chk("bp.valid_drop", 32'(out_valid), 32'd0);
    chk("bp.cnt", 32'(xfer_cnt), 32'd2);
    cycle();
    chk("bp.ack_clear", 32'(ack), 32'd0);
    chk("bp.idle", 32'(busy), 32'd0);

    // ---------------- reset mid-transfer ----------------
    drive(0, 4'b1000, 4'b1000, 32'h77000000, 0);
    cycle();
    chk("rstx.capture_valid", 32'(out_valid), 32'd1);
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    cycle();
    cycle();
    drive(1, 4'b0000, 4'b0000, 32'h0, 0);
    cycle();
    $display("rstx: valid=%0b busy=%0b cnt=%0d", out_valid, busy, xfer_cnt);
    chk("rstx.valid", 32'(out_valid), 32'd0);
    chk("rstx.ack", 32'(ack), 32'd0);
    chk("rstx.busy", 32'(busy), 32'd0);
    chk("rstx.cnt", 32'(xfer_cnt), 32'd0);
    chk("rstx.err", 32'(err_multi), 32'd0);
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    cycle();

    // ---------------- long stall: timeout or indefinite wait ----------------
    drive(0, 4'b0001, 4'b0001, 32'h00000011, 0);
    cycle();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cycle();
      chk($sformatf("tmo.stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tmo.stall%0d_to", i), 32'(to_err), 32'd0);
    end
    cycle();
`ifdef TIMEOUT_EN
    $display("tmo: timeout to_err=%0b valid=%0b", to_err, out_valid);
    chk("tmo.to_err", 32'(to_err), 32'd1);
    chk("tmo.valid", 32'(out_valid), 32'd0);
    chk("tmo.ack", 32'(ack), 32'd0);
    chk("tmo.busy", 32'(busy), 32'd0);
    chk("tmo.cnt", 32'(xfer_cnt), 32'd0);
    cycle();
    chk("tmo.to_clear", 32'(to_err), 32'd0);
    // second attempt: handshake on the TIMEOUT-th cycle wins
    drive(0, 4'b0001, 4'b0001, 32'h00000022, 0);
    cycle();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle();
    out_ready = 1;
    cycle();
    $display("tmo: late handshake ack=%b to_err=%0b", ack, to_err);
    chk("tmo2.ack", 32'(ack), 32'b0001);
    chk("tmo2.to_err", 32'(to_err), 32'd0);
    chk("tmo2.cnt", 32'(xfer_cnt), 32'd1);
`else
    $display("tmo: still waiting valid=%0b to_err=%0b", out_valid, to_err);
    chk("wait.valid", 32'(out_valid), 32'd1);
    chk("wait.to_err", 32'(to_err), 32'd0);
    out_ready = 1;
    cycle();
    chk("wait.ack", 32'(ack), 32'b0001);
    chk("wait.cnt", 32'(xfer_cnt), 32'd1);
`endif
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    cycle();

    // ---------------- randomized run against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] g;
      logic [3:0] q;
      case ($urandom_range(0, 3))
        0:       g = 4'b0000;
        3:       g = 4'($urandom_range(0, 15));
        default: g = 4'(1 << $urandom_range(0, 3));
      endcase
      q = ($urandom_range(0, 3) != 0) ? (g | 4'($urandom_range(0, 15))) : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), g, q, $urandom, ($urandom_range(0, 2) == 0));
      cycle();
      chk("rnd.out_valid", 32'(out_valid), 32'(e_valid));
      chk("rnd.out_data",  32'(out_data),  32'(e_data));
      chk("rnd.out_src",   32'(out_src),   32'(e_src));
      chk("rnd.ack",       32'(ack),       32'(e_ack));
      chk("rnd.busy",      32'(busy),      32'(e_busy));
      chk("rnd.err_multi", 32'(err_multi), 32'(e_err));
      chk("rnd.to_err",    32'(to_err),    32'(e_to));
      chk("rnd.xfer_cnt",  32'(xfer_cnt),  32'(e_cnt));
      if (ack != 0)
        $display("rnd xfer: src=%0d data=%h ack=%b cnt=%0d", out_src, out_data, ack, xfer_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grant_xfer_ctrl.md
Name: grant_xfer_ctrl

Overview:
Downstream consumer of the 4-way round-robin arbiter's one-hot grant vector. Validates the grant against the live request lines and captures the granted requester's data word. Presents the word to a shared sink with a valid/ready handshake, then returns a one-cycle per-port ack to the winning requester. Asserts busy while a transfer is in flight so the arbiter and requesters can hold off.

Parameters:
N, 4, number of requester ports; must match the arbiter width.
DW, 8, data width per port.
SW, 2, source-index width; must equal clog2(N).
TIMEOUT, 8, maximum XFER cycles without out_ready; used only when TIMEOUT_EN is defined. Minimum 1.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
grant  in  N  one-hot grant from the arbiter; sampled only in IDLE.
req  in  N  raw request lines, the same vector the arbiter sees.
wdata  in  N*DW  flattened per-port data; port i occupies bits [i*DW +: DW].
out_valid  out  1  sink data valid.
out_ready  in  1  sink ready.
out_data  out  DW  captured data word.
out_src  out  SW  index of the captured port.
ack  out  N  one-cycle one-hot completion pulse back to the winning requester.
busy  out  1  high in every state except IDLE.
err_multi  out  1  one-cycle pulse when a multi-hot grant is sampled.
to_err  out  1  one-cycle timeout pulse; constant 0 without TIMEOUT_EN.
xfer_cnt  out  16  completed-transfer counter; wraps 0xFFFF to 0.

Behaviour:
- Reset, rst=1 at posedge: state=IDLE. All outputs 0. Timeout counter cleared. Reset anywhere in a transfer (XFER or ACK) aborts it with no ack and no error pulse.
- FSM states: IDLE, XFER, ACK. All outputs are registered.
- IDLE, busy=0, sampled at each posedge:
  - grant==0: stay in IDLE.
  - grant has popcount>1: err_multi=1 for the next cycle; stay in IDLE; capture nothing.
  - grant one-hot at bit k and req[k]==1: out_data<=wdata[k], out_src<=k, out_valid<=1; go to XFER.
  - grant one-hot at bit k and req[k]==0 (stale grant): ignore; stay in IDLE; no error.
- Latency: a grant sampled at edge t gives out_valid high in cycle t+1.
- XFER, busy=1:
  - out_valid stays high; out_data and out_src stay stable until the handshake.
  - On a posedge with out_ready=1: out_valid<=0; ack[out_src]<=1; xfer_cnt increments; go to ACK.
- ACK, busy=1:
  - ack is high for exactly this cycle.
  - At the next posedge: ack<=0; go to IDLE.
  - grant is ignored in ACK and XFER; it is never queued.
- Minimum transfer with out_ready held high:
  - grant edge t; out_valid in cycle t+1; ack in cycle t+2; IDLE in cycle t+3.
  - Maximum acceptance rate is one grant per 3 cycles.
- out_src is held after the transfer until the next capture. out_data is held likewise.
- err_multi and to_err are single-cycle pulses. They never coincide with ack.

Optional Feature:
Macro TIMEOUT_EN.
- Defined:
  - An XFER-cycle counter clears on entry to XFER and increments on each XFER cycle where out_ready=0.
  - If it reaches TIMEOUT with out_ready still 0, then at that posedge: out_valid<=0, to_err<=1 for one cycle, go directly to IDLE.
  - No ack is issued and xfer_cnt is unchanged.
  - If out_ready=1 in the TIMEOUT-th cycle, the handshake wins and the transfer completes normally.
- Undefined: XFER waits for out_ready indefinitely; to_err is tied to 0; no counter logic is built.

Test Plan:
1. Reset: rst=1 for 2 cycles with random grant, req and out_ready -> all outputs 0 throughout, and state is IDLE when rst drops.
2. Single transfer: grant=0100, req=0100, wdata port 2=0xA5, out_ready=1 -> out_valid=1, out_data=0xA5, out_src=2 in cycle t+1; ack=0100 in cycle t+2; busy=0 in cycle t+3; xfer_cnt=1.
3. Backpressure: grant=0001, req=0001, wdata port 0=0x3C, out_ready=0 for 5 cycles then 1 -> out_valid high and out_data=0x3C stable for 6 cycles; a grant=0010 pulse applied during XFER is ignored; exactly one ack=0001.
4. Bad grants: grant=0110 -> err_multi pulses one cycle, no out_valid, busy=0; then grant=1000 with req=0000 -> no response.
5. Reset mid-transfer: rst=1 during the 3rd stalled XFER cycle -> next cycle out_valid=0, ack=0, busy=0; xfer_cnt cleared to 0.
6. With TIMEOUT_EN and TIMEOUT=8: out_ready held at 0 -> out_valid high for 8 cycles, then to_err=1 for one cycle with out_valid=0, no ack, xfer_cnt unchanged; repeat with out_ready=1 in cycle 8 -> normal ack and no to_err.
